fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. Owns the architectural fetch PC, issues word requests to instruction memory over a valid/ready port, and buffers in-order responses in a small queue. Presents one instruction word plus its PC per cycle to the decoder's `inst_b` input under a valid/ready handshake. Handles redirects from the execute stage, discarding stale in-flight responses, and halts fetching when the decoder flags a halt.

---
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decoder-facing
// instruction port, and execute/decode control inputs (redirect, halt).
interface fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_b;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid, imem_resp_data,
      output inst_valid, inst_b, inst_pc,
      input  inst_ready,
      input  redirect_valid, redirect_pc, halt_req
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid, imem_resp_data,
      input  inst_valid, inst_b, inst_pc,
      output inst_ready,
      output redirect_valid, redirect_pc, halt_req
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited word requests, in-order response queue,
// redirect flush with stale-response dropping, sticky halt.
module fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);
   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   entry_t        entry_q [QUEUE_DEPTH];
   logic [AW-1:0] head_q;
   logic [AW-1:0] tail_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] outstanding_q;
   logic [CW-1:0] drop_q;
   logic [31:0]   fetch_pc_q;
   logic [31:0]   resp_pc_q;
   logic          halted_q;

   logic          req_fire;
   logic          push;
   logic          pop;
   logic [CW:0]   credit_used;
   logic [CW-1:0] outstanding_d;
   logic [31:0]   redirect_target;

   // Credits cover both in-flight requests and queued entries, so every
   // response that is kept always has a free slot waiting for it.
   assign credit_used         = {1'b0, outstanding_q} + {1'b0, count_q};
   assign bus.imem_req_valid  = rst_n && !halted_q && (credit_used < {1'b0, DEPTH_C});
   assign bus.imem_req_addr   = fetch_pc_q;
   assign req_fire            = bus.imem_req_valid && bus.imem_req_ready;

   assign push = bus.imem_resp_valid && (drop_q == '0) && !bus.redirect_valid;

   assign bus.inst_valid = (count_q != '0) && !bus.redirect_valid;
   assign bus.inst_b     = entry_q[head_q].inst;
   assign bus.inst_pc    = entry_q[head_q].pc;
   assign pop            = bus.inst_valid && bus.inst_ready;

   assign outstanding_d   = outstanding_q + CW'(req_fire) - CW'(bus.imem_resp_valid);
   assign redirect_target = {bus.redirect_pc[31:2], 2'b00};

   // NOTE: sequential state uses non-blocking assignments only, so every read
   // of a _q register in this block sees the pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
         count_q       <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         halted_q      <= 1'b0;
         // NOTE: the queue storage is reset because the head entry drives
         // inst_b/inst_pc directly and those must read zero out of reset.
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         outstanding_q <= outstanding_d;
         if (bus.redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            fetch_pc_q <= redirect_target;
            resp_pc_q  <= redirect_target;
            drop_q     <= outstanding_d;
            halted_q   <= 1'b0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
         end else begin
            if (req_fire) begin
               fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            if (bus.imem_resp_valid && (drop_q != '0)) begin
               drop_q <= drop_q - CW'(1);
            end
            if (push) begin
               entry_q[tail_q] <= '{inst: bus.imem_resp_data, pc: resp_pc_q};
               tail_q          <= tail_q + AW'(1);
               resp_pc_q       <= resp_pc_q + 32'd4;
            end
            if (pop) begin
               head_q <= head_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
            if (bus.halt_req) begin
               halted_q <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         assert (count_q != DEPTH_C);
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a latency-modelled instruction memory
// predicts the kept instruction stream; a separate monitor checks the decoder port.
module tb_fetch_unit;
   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.master)
   );

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   req_t        pending[$];
   exp_t        sb[$];
   logic [31:0] fired[$];

   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          epoch = 0;
   int          first_valid_cyc = -1;
   int          first_fire_cyc = -1;
   logic [31:0] next_req_pc = RST_PC;
   bit          halted_m = 0;

   int          ready_pct = 100;
   int          mready_pct = 100;
   int          lat_lo = 1;
   int          lat_hi = 1;
   bit          do_redirect = 0;
   bit          do_halt = 0;
   bit          redirect_on_busy = 0;
   bit          busy_hit = 0;
   logic [31:0] redir_pc = '0;
   bit          chk_first = 0;
   logic [31:0] first_pc = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
   endfunction

   // One clock cycle: drive inputs after the falling edge, update the reference
   // model just before the rising edge, then advance the cycle count.
   task automatic step();
      req_t        r;
      logic [31:0] tgt;
      int          lat;
      @(negedge clk);
      bus.inst_ready     = (int'($urandom_range(99)) < ready_pct);
      bus.imem_req_ready = (int'($urandom_range(99)) < mready_pct);
      bus.halt_req       = do_halt;
      bus.redirect_valid = do_redirect;
      bus.redirect_pc    = redir_pc;
      do_halt            = 0;
      do_redirect        = 0;
      if (pending.size() > 0 && pending[0].due <= cyc) begin
         bus.imem_resp_valid = 1'b1;
         bus.imem_resp_data  = mem_word(pending[0].addr);
      end else begin
         bus.imem_resp_valid = 1'b0;
         bus.imem_resp_data  = $urandom;
      end
      #1;
      if (redirect_on_busy && bus.imem_req_valid && bus.imem_req_ready &&
          bus.imem_resp_valid && !bus.redirect_valid) begin
         bus.redirect_valid = 1'b1;
         bus.redirect_pc    = redir_pc;
         redirect_on_busy   = 0;
         busy_hit           = 1;
      end
      check("credit_limit", 32'(pending.size() + sb.size() <= DEPTH), 32'd1);
      if (bus.imem_resp_valid) begin
         r = pending.pop_front();
         if (r.epoch == epoch && !bus.redirect_valid)
            sb.push_back('{pc: r.addr, data: mem_word(r.addr), cyc: cyc});
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         check("req_addr", bus.imem_req_addr, next_req_pc);
         check("req_while_halted", 32'(halted_m), 32'd0);
         next_req_pc = next_req_pc + 32'd4;
         lat = int'($urandom_range(lat_hi, lat_lo));
         pending.push_back('{addr: bus.imem_req_addr, epoch: epoch, due: cyc + lat});
         fired.push_back(bus.imem_req_addr);
         if (first_fire_cyc < 0) first_fire_cyc = cyc;
      end
      if (bus.redirect_valid) begin
         tgt         = {bus.redirect_pc[31:2], 2'b00};
         epoch++;
         sb.delete();
         next_req_pc = tgt;
         halted_m    = 0;
         chk_first   = 1;
         first_pc    = tgt;
      end else if (bus.halt_req) begin
         halted_m = 1;
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n               = 1'b0;
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      bus.inst_ready      = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = '0;
      bus.halt_req        = 1'b0;
      pending.delete();
      sb.delete();
      fired.delete();
      epoch++;
      halted_m        = 0;
      chk_first       = 0;
      next_req_pc     = RST_PC;
      first_valid_cyc = -1;
      first_fire_cyc  = -1;
      #1;
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_req_addr", bus.imem_req_addr, RST_PC);
      check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_inst_b", bus.inst_b, 32'd0);
      check("rst_inst_pc", bus.inst_pc, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   // Monitor: compares the decoder port against the scoreboard every cycle.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            if (bus.redirect_valid) begin
               check("valid_in_redirect", 32'(bus.inst_valid), 32'd0);
            end else if (bus.inst_valid) begin
               if (first_valid_cyc < 0) first_valid_cyc = cyc;
               if (sb.size() == 0 || sb[0].cyc >= cyc) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_valid: got pc 0x%08h expected no instruction (cycle %0d)",
                           bus.inst_pc, cyc);
               end else begin
                  check("inst_pc", bus.inst_pc, sb[0].pc);
                  check("inst_b", bus.inst_b, sb[0].data);
                  if (bus.inst_ready) begin
                     if (chk_first) begin
                        check("first_after_redirect", bus.inst_pc, first_pc);
                        chk_first = 0;
                     end
                     void'(sb.pop_front());
                  end
               end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
               check("inst_valid_due", 32'(bus.inst_valid), 32'd1);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int n_fired;

      // Reset release, 1-cycle memory, decoder always ready.
      do_reset();
      ready_pct = 100; mready_pct = 100; lat_lo = 1; lat_hi = 1;
      repeat (12) step();
      check("first_fire_cycle", 32'(first_fire_cyc), 32'd0);
      check("first_valid_cycle", 32'(first_valid_cyc), 32'd2);
      check("fire_count_min", 32'(fired.size() >= 3), 32'd1);
      for (int i = 0; i < 3; i++)
         if (fired.size() > i) check("seq_req_addr", fired[i], 32'(i * 4));

      // Mid-operation reset, then a 10-cycle decoder stall.
      do_reset();
      ready_pct = 0;
      repeat (10) step();
      check("stall_fire_count", 32'(fired.size()), 32'd2);
      #1;
      check("stall_head_pc", bus.inst_pc, 32'h0);
      ready_pct = 100;
      repeat (12) step();

      // 3-cycle memory with two requests in flight, then redirect to 0x100.
      lat_lo = 3; lat_hi = 3;
      for (int k = 0; k < 20 && pending.size() != 2; k++) step();
      check("two_outstanding", 32'(pending.size()), 32'd2);
      do_redirect = 1; redir_pc = 32'h100;
      repeat (15) step();
      check("redirect_output_seen", 32'(chk_first), 32'd0);

      // Redirect coinciding with a request handshake and a response.
      lat_lo = 1; lat_hi = 1;
      redirect_on_busy = 1; busy_hit = 0; redir_pc = 32'h100;
      for (int k = 0; k < 20 && !busy_hit; k++) step();
      check("busy_redirect_hit", 32'(busy_hit), 32'd1);
      repeat (10) step();
      check("busy_redirect_output_seen", 32'(chk_first), 32'd0);

      // Halt while running: drain, no new requests, then resume at 0x200.
      lat_lo = 1; lat_hi = 2;
      repeat (5) step();
      do_halt = 1;
      step();
      n_fired = fired.size();
      repeat (15) step();
      check("halt_no_new_requests", 32'(fired.size()), 32'(n_fired));
      check("halt_drained", 32'(sb.size() + pending.size()), 32'd0);
      #1;
      check("halt_inst_valid", 32'(bus.inst_valid), 32'd0);
      do_redirect = 1; redir_pc = 32'h200;
      repeat (10) step();
      check("resume_output_seen", 32'(chk_first), 32'd0);

      // Halt and redirect together: redirect wins, fetching continues.
      do_halt = 1; do_redirect = 1; redir_pc = 32'h0000_0103;
      step();
      fired.delete();
      repeat (10) step();
      check("halt_redirect_fetching", 32'(fired.size() > 0), 32'd1);
      if (fired.size() > 0) check("unaligned_redirect_addr", fired[0], 32'h100);
      check("unaligned_output_seen", 32'(chk_first), 32'd0);

      // Sequential wrap at the top of the address space.
      do_redirect = 1; redir_pc = 32'hFFFF_FFF8;
      step();
      fired.delete();
      repeat (12) step();
      check("wrap_fire_count", 32'(fired.size() >= 4), 32'd1);
      if (fired.size() >= 4) begin
         check("wrap_addr0", fired[0], 32'hFFFF_FFF8);
         check("wrap_addr1", fired[1], 32'hFFFF_FFFC);
         check("wrap_addr2", fired[2], 32'h0000_0000);
         check("wrap_addr3", fired[3], 32'h0000_0004);
      end

      // Random traffic: variable latency, backpressure, redirects and halts.
      ready_pct = 70; mready_pct = 70; lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99) < 3) begin
            do_redirect = 1;
            redir_pc    = $urandom;
         end else if ($urandom_range(99) < 2) begin
            do_halt = 1;
         end
         step();
      end

      // Final drain under halt.
      ready_pct = 100; mready_pct = 100;
      do_halt = 1;
      repeat (30) step();
      check("final_drain", 32'(sb.size() + pending.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
